// File: rtl/exec_stage.sv
// Execute stage: operand forwarding, 16-bit ALU, CCR with interrupt
// shadow, and the execute/memory boundary register.
module exec_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic [34:0] control_signals_execute,
    input  logic [2:0]  Rs_execute,
    input  logic [2:0]  Rd_execute,
    input  logic [15:0] Rs_data_execute,
    input  logic [15:0] Rd_data_execute,
    input  logic [15:0] Imm_value_execute,
    input  logic [4:0]  shmnt_execute,
    input  logic        int1_execute,
    input  logic        int2_execute,
    input  logic [31:0] pcBeforeInterrupt_execeute,
    input  logic        fwd_mem_en,
    input  logic [2:0]  fwd_mem_rd,
    input  logic [15:0] fwd_mem_data,
    input  logic        fwd_wb_en,
    input  logic [2:0]  fwd_wb_rd,
    input  logic [15:0] fwd_wb_data,
    output logic [15:0] alu_result_mem,
    output logic [15:0] store_data_mem,
    output logic [2:0]  Rd_mem,
    output logic [34:0] control_signals_mem,
    output logic        int1_mem,
    output logic        int2_mem,
    output logic [31:0] pcBeforeInterrupt_mem,
    output logic [2:0]  ccr
);

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_NOT  = 4'h5;
    localparam logic [3:0] OP_INC  = 4'h6;
    localparam logic [3:0] OP_DEC  = 4'h7;
    localparam logic [3:0] OP_SHL  = 4'h8;
    localparam logic [3:0] OP_SHR  = 4'h9;
    localparam logic [3:0] OP_MOV  = 4'hA;
    localparam logic [3:0] OP_SETC = 4'hB;
    localparam logic [3:0] OP_CLRC = 4'hC;

    logic [3:0] alu_op;
    logic       use_imm;
    logic       flag_we;
    logic       ccr_restore;

    assign alu_op      = control_signals_execute[3:0];
    assign use_imm     = control_signals_execute[4];
    assign flag_we     = control_signals_execute[5];
    assign ccr_restore = control_signals_execute[7];

    logic [15:0] op_a;
    logic [15:0] rs_fwd;
    logic [15:0] op_b;

    // Operand forwarding: memory stage is younger, so it wins.
    always_comb begin
        op_a = Rd_data_execute;
        if (fwd_mem_en && fwd_mem_rd == Rd_execute) begin
            op_a = fwd_mem_data;
        end else if (fwd_wb_en && fwd_wb_rd == Rd_execute) begin
            op_a = fwd_wb_data;
        end
        rs_fwd = Rs_data_execute;
        if (fwd_mem_en && fwd_mem_rd == Rs_execute) begin
            rs_fwd = fwd_mem_data;
        end else if (fwd_wb_en && fwd_wb_rd == Rs_execute) begin
            rs_fwd = fwd_wb_data;
        end
        op_b = use_imm ? Imm_value_execute : rs_fwd;
    end

    logic [2:0]  ccr_q, ccr_d;
    logic [2:0]  shadow_q, shadow_d;
    logic [15:0] res;
    logic        c_new;
    logic        c_wr;
    logic        c_force;
    logic        nz_wr;
    logic [16:0] sum_ext;
    logic [16:0] shl_ext;
    logic [16:0] shr_ext;

    // ALU result and which flags the operation may touch.
    always_comb begin
        res     = op_a;
        c_new   = ccr_q[2];
        c_wr    = 1'b0;
        c_force = 1'b0;
        nz_wr   = 1'b0;
        sum_ext = 17'd0;
        shl_ext = {1'b0, op_a} << shmnt_execute;
        shr_ext = {op_a, 1'b0} >> shmnt_execute;
        unique case (alu_op)
            OP_NOP: res = op_a;
            OP_ADD: begin
                sum_ext = {1'b0, op_a} + {1'b0, op_b};
                res     = sum_ext[15:0];
                c_new   = sum_ext[16];
                c_wr    = 1'b1;
                nz_wr   = 1'b1;
            end
            OP_SUB: begin
                res   = op_a - op_b;
                c_new = op_a < op_b;
                c_wr  = 1'b1;
                nz_wr = 1'b1;
            end
            OP_AND: begin
                res   = op_a & op_b;
                nz_wr = 1'b1;
            end
            OP_OR: begin
                res   = op_a | op_b;
                nz_wr = 1'b1;
            end
            OP_NOT: begin
                res   = ~op_a;
                nz_wr = 1'b1;
            end
            OP_INC: begin
                sum_ext = {1'b0, op_a} + 17'd1;
                res     = sum_ext[15:0];
                c_new   = sum_ext[16];
                c_wr    = 1'b1;
                nz_wr   = 1'b1;
            end
            OP_DEC: begin
                res   = op_a - 16'd1;
                c_new = op_a == 16'd0;
                c_wr  = 1'b1;
                nz_wr = 1'b1;
            end
            OP_SHL: begin
                nz_wr = 1'b1;
                if (shmnt_execute == 5'd0) begin
                    res = op_a;
                end else if (shmnt_execute[4]) begin
                    res   = 16'd0;
                    c_new = 1'b0;
                    c_wr  = 1'b1;
                end else begin
                    res   = shl_ext[15:0];
                    c_new = shl_ext[16];
                    c_wr  = 1'b1;
                end
            end
            OP_SHR: begin
                nz_wr = 1'b1;
                if (shmnt_execute == 5'd0) begin
                    res = op_a;
                end else if (shmnt_execute[4]) begin
                    res   = 16'd0;
                    c_new = 1'b0;
                    c_wr  = 1'b1;
                end else begin
                    res   = shr_ext[16:1];
                    c_new = shr_ext[0];
                    c_wr  = 1'b1;
                end
            end
            OP_MOV: begin
                res   = op_b;
                nz_wr = 1'b1;
            end
            OP_SETC: begin
                c_new   = 1'b1;
                c_force = 1'b1;
            end
            OP_CLRC: begin
                c_new   = 1'b0;
                c_force = 1'b1;
            end
            default: res = op_a;
        endcase
    end

    // CCR/shadow next state; restore beats every other CCR writer.
    always_comb begin
        ccr_d    = ccr_q;
        shadow_d = shadow_q;
        if (!stall && !flush) begin
            if (int1_execute) begin
                shadow_d = ccr_q;
            end
            if (ccr_restore) begin
                ccr_d = shadow_q;
            end else begin
                if (flag_we && nz_wr) begin
                    ccr_d[1] = res[15];
                    ccr_d[0] = res == 16'd0;
                end
                if ((flag_we && c_wr) || c_force) begin
                    ccr_d[2] = c_new;
                end
            end
        end
    end

    logic [15:0] alu_result_q, alu_result_d;
    logic [15:0] store_data_q, store_data_d;
    logic [2:0]  rd_q, rd_d;
    logic [34:0] ctrl_q, ctrl_d;
    logic        int1_q, int1_d;
    logic        int2_q, int2_d;
    logic [31:0] pc_q, pc_d;

    // Boundary register next state: hold on stall, bubble on flush.
    always_comb begin
        alu_result_d = alu_result_q;
        store_data_d = store_data_q;
        rd_d         = rd_q;
        ctrl_d       = ctrl_q;
        int1_d       = int1_q;
        int2_d       = int2_q;
        pc_d         = pc_q;
        if (!stall) begin
            if (flush) begin
                alu_result_d = 16'd0;
                store_data_d = 16'd0;
                rd_d         = 3'd0;
                ctrl_d       = 35'd0;
                int1_d       = 1'b0;
                int2_d       = 1'b0;
                pc_d         = 32'd0;
            end else begin
                alu_result_d = res;
                store_data_d = rs_fwd;
                rd_d         = Rd_execute;
                ctrl_d       = control_signals_execute;
                int1_d       = int1_execute;
                int2_d       = int2_execute;
                pc_d         = pcBeforeInterrupt_execeute;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_result_q <= 16'd0;
            store_data_q <= 16'd0;
            rd_q         <= 3'd0;
            ctrl_q       <= 35'd0;
            int1_q       <= 1'b0;
            int2_q       <= 1'b0;
            pc_q         <= 32'd0;
            ccr_q        <= 3'd0;
            shadow_q     <= 3'd0;
        end else begin
            alu_result_q <= alu_result_d;
            store_data_q <= store_data_d;
            rd_q         <= rd_d;
            ctrl_q       <= ctrl_d;
            int1_q       <= int1_d;
            int2_q       <= int2_d;
            pc_q         <= pc_d;
            ccr_q        <= ccr_d;
            shadow_q     <= shadow_d;
        end
    end

    assign alu_result_mem        = alu_result_q;
    assign store_data_mem        = store_data_q;
    assign Rd_mem                = rd_q;
    assign control_signals_mem   = ctrl_q;
    assign int1_mem              = int1_q;
    assign int2_mem              = int2_q;
    assign pcBeforeInterrupt_mem = pc_q;
    assign ccr                   = ccr_q;

endmodule

// File: tb/tb_exec_stage.sv
// Directed bench for exec_stage: vector table plus
// stall/flush/reset sequences.
module tb_exec_stage;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        flush;
    logic [34:0] ctrl;
    logic [2:0]  rs_i, rd_i;
    logic [15:0] rs_dat, rd_dat, imm;
    logic [4:0]  sh;
    logic        int1, int2;
    logic [31:0] pc;
    logic        me, we;
    logic [2:0]  mr, wr;
    logic [15:0] md, wd;
    logic [15:0] res_o, st_o;
    logic [2:0]  rd_o;
    logic [34:0] ctrl_o;
    logic        int1_o, int2_o;
    logic [31:0] pc_o;
    logic [2:0]  ccr_o;

    int errors = 0;
    int checks = 0;

    exec_stage dut (
        .clk(clk),
        .rst(rst),
        .stall(stall),
        .flush(flush),
        .control_signals_execute(ctrl),
        .Rs_execute(rs_i),
        .Rd_execute(rd_i),
        .Rs_data_execute(rs_dat),
        .Rd_data_execute(rd_dat),
        .Imm_value_execute(imm),
        .shmnt_execute(sh),
        .int1_execute(int1),
        .int2_execute(int2),
        .pcBeforeInterrupt_execeute(pc),
        .fwd_mem_en(me),
        .fwd_mem_rd(mr),
        .fwd_mem_data(md),
        .fwd_wb_en(we),
        .fwd_wb_rd(wr),
        .fwd_wb_data(wd),
        .alu_result_mem(res_o),
        .store_data_mem(st_o),
        .Rd_mem(rd_o),
        .control_signals_mem(ctrl_o),
        .int1_mem(int1_o),
        .int2_mem(int2_o),
        .pcBeforeInterrupt_mem(pc_o),
        .ccr(ccr_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  op;
        logic        ie;
        logic        fwe;
        logic        rsto;
        logic        i1;
        logic [2:0]  rd;
        logic [2:0]  rs;
        logic [15:0] rdd;
        logic [15:0] rsd;
        logic [15:0] im;
        logic [4:0]  sh;
        logic        me;
        logic [2:0]  mr;
        logic [15:0] md;
        logic        we;
        logic [2:0]  wr;
        logic [15:0] wd;
        logic [15:0] e_res;
        logic [15:0] e_st;
        logic [2:0]  e_ccr;
    } vec_t;

    localparam int NV = 23;
    vec_t vt [NV];

    task automatic chk(input string nm, input int idx,
                       input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %0h expected %0h",
                     nm, idx, act, exp);
        end
    endtask

    function automatic logic [34:0] mkctrl(
        input logic [3:0] op, input logic ie,
        input logic fwe, input logic rsto, input int i);
        logic [26:0] up;
        up = 27'h1234567 ^ 27'(i);
        return {up, rsto, 1'b1, fwe, ie, op};
    endfunction

    task automatic idle();
        stall = 0; flush = 0; ctrl = '0;
        rs_i = 0; rd_i = 0; rs_dat = 0; rd_dat = 0;
        imm = 0; sh = 0; int1 = 0; int2 = 0; pc = 0;
        me = 0; we = 0; mr = 0; wr = 0; md = 0; wd = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vt[0]  = '{4'h1,0,1,0,0,3'd1,3'd2,16'h7FFF,16'h0001,16'h0,5'd0,
                   0,3'd0,16'h0,0,3'd0,16'h0,16'h8000,16'h0001,3'b010};
        vt[1]  = '{4'h0,0,0,0,0,3'd2,3'd3,16'h0000,16'h0000,16'h0,5'd0,
                   1,3'd2,16'h1234,1,3'd2,16'h9999,16'h1234,16'h0000,3'b010};
        vt[2]  = '{4'h0,0,0,0,0,3'd2,3'd3,16'h0000,16'h0000,16'h0,5'd0,
                   0,3'd2,16'h1234,1,3'd2,16'h9999,16'h9999,16'h0000,3'b010};
        vt[3]  = '{4'h2,1,1,0,0,3'd1,3'd2,16'h0003,16'h00AA,16'h5,5'd0,
                   0,3'd0,16'h0,0,3'd0,16'h0,16'hFFFE,16'h00AA,3'b110};
        vt[4]  = '{4'h2,1,1,0,0,3'd1,3'd2,16'h0005,16'h00AA,16'h5,5'd0,
                   0,3'd0,16'h0,0,3'd0,16'h0,16'h0000,16'h00AA,3'b001};
        vt[5]  = '{4'h8,0,1,0,0,3'd1,3'd2,16'h8001,16'h0000,16'h0,5'd1,
                   0,3'd0,16'h0,0,3'd0,16'h0,16'h0002,16'h0000,3'b100};
        vt[6]  = '{4'h9,0,1,0,0,3'd1,3'd2,16'h1234,16'h0000,16'h0,5'd0,
                   0,3'd0,16'h0,0,3'd0,16'h0,16'h1234,16'h0000,3'b100};
        vt[7]  = '{4'h9,0,1,0,0,3'd1,3'd2,16'hFFFF,16'h0000,16'h0,5'd20,
                   0,3'd0,16'h0,0,3'd0,16'h0,16'h0000,16'h0000,3'b001};
        vt[8]  = '{4'hB,0,0,0,0,3'd1,3'd2,16'h0055,16'h0000,16'h0,5'd0,
                   0,3'd0,16'h0,0,3'd0,16'h0,16'h0055,16'h0000,3'b101};
        vt[9]  = '{4'h1,0,1,0,1,3'd1,3'd2,16'h0001,16'h0001,16'h0,5'd0,
                   0,3'd0,16'h0,0,3'd0,16'h0,16'h0002,16'h0001,3'b000};
        vt[10] = '{4'h1,0,1,1,0,3'd1,3'd2,16'hFFFF,16'h0001,16'h0,5'd0,
                   0,3'd0,16'h0,0,3'd0,16'h0,16'h0000,16'h0001,3'b101};
        vt[11] = '{4'h3,0,1,0,0,3'd1,3'd2,16'hF0F0,16'h0FF0,16'h0,5'd0,
                   0,3'd0,16'h0,0,3'd0,16'h0,16'h00F0,16'h0FF0,3'b100};
        vt[12] = '{4'h4,0,1,0,0,3'd1,3'd2,16'hF000,16'h000F,16'h0,5'd0,
                   0,3'd0,16'h0,0,3'd0,16'h0,16'hF00F,16'h000F,3'b110};
        vt[13] = '{4'h5,0,1,0,0,3'd1,3'd2,16'hFFFF,16'h0000,16'h0,5'd0,
                   0,3'd0,16'h0,0,3'd0,16'h0,16'h0000,16'h0000,3'b101};
        vt[14] = '{4'h6,0,1,0,0,3'd1,3'd2,16'hFFFF,16'h0000,16'h0,5'd0,
                   0,3'd0,16'h0,0,3'd0,16'h0,16'h0000,16'h0000,3'b101};
        vt[15] = '{4'h7,0,1,0,0,3'd1,3'd2,16'h0000,16'h0000,16'h0,5'd0,
                   0,3'd0,16'h0,0,3'd0,16'h0,16'hFFFF,16'h0000,3'b110};
        vt[16] = '{4'hA,1,1,0,0,3'd1,3'd2,16'h1234,16'h0000,16'h0,5'd0,
                   0,3'd0,16'h0,0,3'd0,16'h0,16'h0000,16'h0000,3'b101};
        vt[17] = '{4'hC,0,1,0,0,3'd1,3'd2,16'h8000,16'h0000,16'h0,5'd0,
                   0,3'd0,16'h0,0,3'd0,16'h0,16'h8000,16'h0000,3'b001};
        vt[18] = '{4'hD,0,1,0,0,3'd1,3'd2,16'h1234,16'h0000,16'h0,5'd0,
                   0,3'd0,16'h0,0,3'd0,16'h0,16'h1234,16'h0000,3'b001};
        vt[19] = '{4'h9,0,1,0,0,3'd1,3'd2,16'h8003,16'h0000,16'h0,5'd2,
                   0,3'd0,16'h0,0,3'd0,16'h0,16'h2000,16'h0000,3'b100};
        vt[20] = '{4'h1,0,1,0,0,3'd1,3'd3,16'h0020,16'h0000,16'h0,5'd0,
                   1,3'd5,16'h7777,1,3'd3,16'h0010,16'h0030,16'h0010,3'b000};
        vt[21] = '{4'h0,0,0,1,1,3'd1,3'd2,16'h0000,16'h0000,16'h0,5'd0,
                   0,3'd0,16'h0,0,3'd0,16'h0,16'h0000,16'h0000,3'b101};
        vt[22] = '{4'h0,0,0,1,0,3'd1,3'd2,16'h0000,16'h0000,16'h0,5'd0,
                   0,3'd0,16'h0,0,3'd0,16'h0,16'h0000,16'h0000,3'b000};

        idle();
        rst = 1;
        tick();
        tick();
        chk("rst_res", 0, 64'(res_o), 64'h0);
        chk("rst_st", 0, 64'(st_o), 64'h0);
        chk("rst_rd", 0, 64'(rd_o), 64'h0);
        chk("rst_ctrl", 0, 64'(ctrl_o), 64'h0);
        chk("rst_int", 0, 64'({int1_o, int2_o}), 64'h0);
        chk("rst_pc", 0, 64'(pc_o), 64'h0);
        chk("rst_ccr", 0, 64'(ccr_o), 64'h0);
        rst = 0;

        for (int i = 0; i < NV; i++) begin
            ctrl   = mkctrl(vt[i].op, vt[i].ie, vt[i].fwe,
                            vt[i].rsto, i);
            rd_i   = vt[i].rd;
            rs_i   = vt[i].rs;
            rd_dat = vt[i].rdd;
            rs_dat = vt[i].rsd;
            imm    = vt[i].im;
            sh     = vt[i].sh;
            int1   = vt[i].i1;
            int2   = i[0];
            pc     = 32'hC0DE_0000 + 32'(i);
            me = vt[i].me; mr = vt[i].mr; md = vt[i].md;
            we = vt[i].we; wr = vt[i].wr; wd = vt[i].wd;
            tick();
            chk("res", i, 64'(res_o), 64'(vt[i].e_res));
            chk("store", i, 64'(st_o), 64'(vt[i].e_st));
            chk("ccr", i, 64'(ccr_o), 64'(vt[i].e_ccr));
            chk("rd", i, 64'(rd_o), 64'(vt[i].rd));
            chk("ctrl", i, 64'(ctrl_o),
                64'(mkctrl(vt[i].op, vt[i].ie, vt[i].fwe,
                           vt[i].rsto, i)));
            chk("int", i, 64'({int1_o, int2_o}),
                64'({vt[i].i1, i[0]}));
            chk("pc", i, 64'(pc_o), 64'(32'hC0DE_0000 + 32'(i)));
        end

        // Reference instruction: ADD 1+1 into R4, flags clear.
        idle();
        ctrl = mkctrl(4'h1, 0, 1, 0, 40);
        rd_i = 3'd4; rd_dat = 16'h0001; rs_dat = 16'h0001;
        pc = 32'hAAAA_0001;
        tick();
        chk("ref_res", 0, 64'(res_o), 64'h2);
        chk("ref_ccr", 0, 64'(ccr_o), 64'h0);

        // Stall for three cycles with a CCR-changing op presented.
        ctrl = mkctrl(4'hB, 0, 1, 0, 41);
        rd_i = 3'd6; rd_dat = 16'hFFFF; int1 = 1;
        pc = 32'h5555_0000;
        stall = 1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("stall_res", k, 64'(res_o), 64'h2);
            chk("stall_rd", k, 64'(rd_o), 64'h4);
            chk("stall_ctrl", k, 64'(ctrl_o),
                64'(mkctrl(4'h1, 0, 1, 0, 40)));
            chk("stall_pc", k, 64'(pc_o), 64'hAAAA_0001);
            chk("stall_ccr", k, 64'(ccr_o), 64'h0);
        end

        flush = 1;
        tick();
        chk("stfl_res", 0, 64'(res_o), 64'h2);
        chk("stfl_ctrl", 0, 64'(ctrl_o),
            64'(mkctrl(4'h1, 0, 1, 0, 40)));
        chk("stfl_ccr", 0, 64'(ccr_o), 64'h0);

        stall = 0;
        tick();
        chk("flush_ctrl", 0, 64'(ctrl_o), 64'h0);
        chk("flush_res", 0, 64'(res_o), 64'h0);
        chk("flush_rd", 0, 64'(rd_o), 64'h0);
        chk("flush_int", 0, 64'({int1_o, int2_o}), 64'h0);
        chk("flush_ccr", 0, 64'(ccr_o), 64'h0);

        // Shadow untouched by the flushed int1: restore gives 000.
        flush = 0; int1 = 0;
        ctrl = mkctrl(4'hB, 0, 0, 0, 42);
        tick();
        chk("setc_ccr", 0, 64'(ccr_o), 64'b100);
        chk("setc_res", 0, 64'(res_o), 64'hFFFF);
        ctrl = mkctrl(4'h0, 0, 0, 1, 43);
        tick();
        chk("rest_ccr", 0, 64'(ccr_o), 64'b000);

        // Reset overrides stall and flush.
        ctrl = mkctrl(4'hB, 0, 0, 0, 44);
        tick();
        chk("pre_rst_ccr", 0, 64'(ccr_o), 64'b100);
        rst = 1; stall = 1; flush = 1;
        tick();
        chk("rst2_res", 0, 64'(res_o), 64'h0);
        chk("rst2_ctrl", 0, 64'(ctrl_o), 64'h0);
        chk("rst2_ccr", 0, 64'(ccr_o), 64'h0);
        rst = 0; stall = 0; flush = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
